// File: rtl/fuzz_arith_core_pkg.sv
// Shared widths, y-packing layout and pipeline record types for fuzz_arith_core.
// Every stage register is a plain unsigned record; signedness is applied where the arithmetic happens.
package fuzz_arith_core_pkg;

    localparam int A_W = 19;
    localparam int B_W = 18;
    localparam int C_W = 11;
    localparam int D_W = 14;

    localparam int SUM_W  = 20;
    localparam int PROD_W = 25;
    localparam int XOR_W  = 19;
    localparam int ACC_W  = 48;
    localparam int CNT_W  = 32;
    localparam int MAX_W  = 20;
    localparam int ABS_W  = 20;
    localparam int FLG_W  = 4;
    localparam int Y_W    = 192;

    localparam int SUM_LSB  = 0;
    localparam int PROD_LSB = 20;
    localparam int XOR_LSB  = 45;
    localparam int ACC_LSB  = 64;
    localparam int CNT_LSB  = 112;
    localparam int MAX_LSB  = 144;
    localparam int ABS_LSB  = 164;
    localparam int S1F_LSB  = 184;
    localparam int S2F_LSB  = 188;

    typedef struct packed {
        logic [FLG_W-1:0]  flags;
        logic [XOR_W-1:0]  xr;
        logic [PROD_W-1:0] prod;
        logic [SUM_W-1:0]  sum;
    } s1_t;

    typedef struct packed {
        logic [FLG_W-1:0] flags;
        logic [ABS_W-1:0] absdiff;
        logic [MAX_W-1:0] max;
        logic [ACC_W-1:0] acc;
    } s2_t;

endpackage

// File: rtl/fuzz_arith_core_stage2.sv
// Second pipeline stage: product accumulator, signed max / absolute difference
// of the stage-1 sum and xor, and the stage-2 flag nibble.
module fuzz_arith_core_stage2
    import fuzz_arith_core_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [SUM_W-1:0]  sum_i,
    input  logic [PROD_W-1:0] prod_i,
    input  logic [XOR_W-1:0]  xor_i,
    output s2_t               s2_o
);

    s2_t s2_d, s2_q;

    logic signed [SUM_W-1:0] sum_s;
    logic signed [SUM_W-1:0] xor_ext;
    logic signed [SUM_W:0]   diff;
    logic signed [SUM_W:0]   abs_full;
    logic        [ACC_W-1:0] acc_next;

    always_comb begin
        sum_s    = sum_i;
        xor_ext  = {xor_i[XOR_W-1], xor_i};
        // One guard bit keeps the subtraction exact; the magnitude always fits in 20 bits.
        diff     = {sum_s[SUM_W-1], sum_s} - {xor_ext[SUM_W-1], xor_ext};
        abs_full = diff[SUM_W] ? -diff : diff;
        acc_next = s2_q.acc + {{(ACC_W-PROD_W){prod_i[PROD_W-1]}}, prod_i};

        s2_d         = s2_q;
        s2_d.acc     = acc_next;
        s2_d.max     = (sum_s > xor_ext) ? sum_s : xor_ext;
        s2_d.absdiff = abs_full[ABS_W-1:0];
        s2_d.flags   = {^xor_i, prod_i == '0, sum_s > xor_ext, acc_next[ACC_W-1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_q <= '0;
        end else begin
            s2_q <= s2_d;
        end
    end

    assign s2_o = s2_q;

endmodule

// File: rtl/fuzz_arith_core.sv
// Two-stage signed arithmetic datapath with a free-running cycle counter;
// every field of y comes straight from a register.
module fuzz_arith_core
    import fuzz_arith_core_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic signed [A_W-1:0] wire0,
    input  logic signed [B_W-1:0] wire1,
    input  logic signed [C_W-1:0] wire2,
    input  logic signed [D_W-1:0] wire3,
    output logic [Y_W-1:0]        y
);

    s1_t              s1_d, s1_q;
    s2_t              s2;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    logic signed [PROD_W-1:0] c_ext, d_ext;
    logic signed [XOR_W-1:0]  b_ext;

    always_comb begin
        c_ext = {{(PROD_W-C_W){wire2[C_W-1]}}, wire2};
        d_ext = {{(PROD_W-D_W){wire3[D_W-1]}}, wire3};
        b_ext = {{(XOR_W-B_W){wire1[B_W-1]}}, wire1};

        s1_d       = '0;
        s1_d.sum   = {{(SUM_W-A_W){wire0[A_W-1]}}, wire0}
                   + {{(SUM_W-B_W){wire1[B_W-1]}}, wire1};
        s1_d.prod  = c_ext * d_ext;
        s1_d.xr    = wire0 ^ b_ext;
        s1_d.flags = {d_ext > c_ext, wire2 == '0, wire1[B_W-1], wire0[A_W-1]};

        cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q  <= '0;
            cnt_q <= '0;
        end else begin
            s1_q  <= s1_d;
            cnt_q <= cnt_d;
        end
    end

    fuzz_arith_core_stage2 u_stage2 (
        .clk    (clk),
        .rst    (rst),
        .sum_i  (s1_q.sum),
        .prod_i (s1_q.prod),
        .xor_i  (s1_q.xr),
        .s2_o   (s2)
    );

    always_comb begin
        y = '0;
        y[SUM_LSB  +: SUM_W]  = s1_q.sum;
        y[PROD_LSB +: PROD_W] = s1_q.prod;
        y[XOR_LSB  +: XOR_W]  = s1_q.xr;
        y[ACC_LSB  +: ACC_W]  = s2.acc;
        y[CNT_LSB  +: CNT_W]  = cnt_q;
        y[MAX_LSB  +: MAX_W]  = s2.max;
        y[ABS_LSB  +: ABS_W]  = s2.absdiff;
        y[S1F_LSB  +: FLG_W]  = s1_q.flags;
        y[S2F_LSB  +: FLG_W]  = s2.flags;
    end

endmodule

// File: tb/tb_fuzz_arith_core.sv
// Directed-vector bench for fuzz_arith_core; expected values are hand-computed
// and y fields are sliced with literal bit ranges.
module tb_fuzz_arith_core;

    logic               clk;
    logic               rst;
    logic signed [18:0] wire0;
    logic signed [17:0] wire1;
    logic signed [10:0] wire2;
    logic signed [13:0] wire3;
    logic [191:0]       y;

    int n_checks;
    int n_errors;

    fuzz_arith_core dut (
        .clk   (clk),
        .rst   (rst),
        .wire0 (wire0),
        .wire1 (wire1),
        .wire2 (wire2),
        .wire3 (wire3),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int a, input int b, input int c, input int d);
        wire0 = a[18:0];
        wire1 = b[17:0];
        wire2 = c[10:0];
        wire3 = d[13:0];
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [47:0] p_big;
    logic [47:0] exp_acc;

    initial begin
        n_checks = 0;
        n_errors = 0;
        p_big    = 48'h000000800000;

        // Reset held for two edges with arbitrary operands.
        rst = 1'b1;
        drive($urandom_range(0, 32'h7FFFF), $urandom_range(0, 32'h3FFFF),
              $urandom_range(0, 32'h7FF), $urandom_range(0, 32'h3FFF));
        tick(1);
        drive($urandom_range(0, 32'h7FFFF), $urandom_range(0, 32'h3FFFF),
              $urandom_range(0, 32'h7FF), $urandom_range(0, 32'h3FFF));
        tick(1);
        check("rst_y", y, 192'h0);

        // Small mixed-sign vector.
        rst = 1'b0;
        drive(5, -3, 7, -2);
        tick(1);
        check("v1_cnt",     y[143:112], 32'd1);
        check("v1_sum",     y[19:0],    20'h00002);
        check("v1_prod",    y[44:20],   25'h1FFFFF2);
        check("v1_xor",     y[63:45],   19'h7FFF8);
        check("v1_s1flags", y[187:184], 4'b0010);
        check("v1_acc_lag", y[111:64],  48'h0);
        tick(1);
        check("v1_acc",     y[111:64],  48'hFFFFFFFFFFF2);
        check("v1_max",     y[163:144], 20'h00002);
        check("v1_absdiff", y[183:164], 20'h0000A);
        check("v1_s2flags", y[191:188], 4'b0011);
        check("v1_cnt2",    y[143:112], 32'd2);

        // Operand extremes; acc keeps running from the previous vector.
        drive(-262144, -131072, -1024, -8192);
        tick(1);
        check("ext_sum",     y[19:0],    20'hA0000);
        check("ext_prod",    y[44:20],   25'h0800000);
        check("ext_xor",     y[63:45],   19'h20000);
        check("ext_s1flags", y[187:184], 4'b0011);
        check("ext_acc1",    y[111:64],  48'hFFFFFFFFFFE4);
        tick(1);
        check("ext_max",     y[163:144], 20'h20000);
        check("ext_absdiff", y[183:164], 20'h80000);
        check("ext_s2flags", y[191:188], 4'b1000);
        check("ext_acc2",    y[111:64],  48'h0000007FFFE4);

        // Accumulation from a fresh reset.
        rst = 1'b1;
        tick(1);
        check("acc_rst_y", y, 192'h0);
        rst = 1'b0;
        drive(0, 0, -1024, -8192);
        for (int k = 1; k <= 4; k++) begin
            tick(1);
            exp_acc = p_big * 48'(k - 1);
            check("acc_run", y[111:64], exp_acc);
        end
        check("acc_cnt", y[143:112], 32'd4);
        check("acc_final", y[111:64], 48'h000001800000);

        // Reset in the middle of accumulation.
        rst = 1'b1;
        tick(1);
        check("mid_rst_y", y, 192'h0);
        rst = 1'b0;
        tick(1);
        check("mid_acc0", y[111:64],  48'h0);
        check("mid_cnt1", y[143:112], 32'd1);
        check("mid_prod", y[44:20],   25'h0800000);
        tick(1);
        check("mid_acc1", y[111:64],  48'h000000800000);
        check("mid_cnt2", y[143:112], 32'd2);

        // Counter wrap via backdoor preload.
        force dut.cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.cnt_q;
        tick(1);
        check("wrap_cnt",     y[143:112], 32'h0);
        check("wrap_acc",     y[111:64],  48'h000001000000);
        check("wrap_prod",    y[44:20],   25'h0800000);
        check("wrap_sum",     y[19:0],    20'h0);
        check("wrap_s2flags", y[191:188], 4'b0000);
        tick(1);
        check("wrap_cnt1",    y[143:112], 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
